// File: rtl/vco_pkg.sv
// ---------------------------------------------------------------------------
// vco_pkg
//   Shared constants and types for the VCO-ADC digital back-end.
//   No ports; imported by vco_fine_decoder and vco_sample_decoder.
// ---------------------------------------------------------------------------
package vco_pkg;

  localparam int VcoCoarseWidth       = 26;
  localparam int VcoFineWidth         = 31;
  localparam int VcoFineBinWidth      = 6;
  localparam int VcoDataWidth         = 32;
  localparam int VcoTrigger2drDelayCc = 3;

  // Each ring phase is visited twice per coarse count (rising then falling
  // wave front), so one coarse step spans 2*FineWidth linear phase units.
  localparam int VcoFineStates = 2 * VcoFineWidth;

  typedef logic [VcoDataWidth-1:0] vco_phase_t;

  // Linear phase wraps here, not at 2^32.
  localparam vco_phase_t VcoPhaseMod = vco_phase_t'(VcoFineStates) << VcoCoarseWidth;

endpackage

// File: rtl/vco_fine_decoder.sv
// ---------------------------------------------------------------------------
// vco_fine_decoder
//   Combinational decode of the ring-oscillator snapshot into a linear fine
//   phase (0 .. 2*FineWidth-1), plus a legality check on the code shape.
//
//   fine_i      in   FineWidth     pseudo-thermometer ring snapshot
//   fine_bin_o  out  FineBinWidth  decoded fine phase
//   legal_o     out  1             1 when fine_i is a legal code
// ---------------------------------------------------------------------------
module vco_fine_decoder
  import vco_pkg::*;
#(
  parameter int FineWidth    = VcoFineWidth,
  parameter int FineBinWidth = VcoFineBinWidth
) (
  input  logic [FineWidth-1:0]    fine_i,
  output logic [FineBinWidth-1:0] fine_bin_o,
  output logic                    legal_o
);

  logic [FineBinWidth-1:0] ones;
  logic [FineWidth-1:0]    low_run;
  logic [FineWidth-1:0]    high_run;

  assign ones = FineBinWidth'($countones(fine_i));

  // The only legal shapes with a given popcount are a run of ones anchored
  // at bit 0 (rising half) or a run of ones anchored at the top bit
  // (falling half). Build both reference codes and compare.
  always_comb begin
    low_run  = '0;
    high_run = '0;
    for (int i = 0; i < FineWidth; i++) begin
      low_run[i]  = (i < int'(ones));
      high_run[i] = (i >= FineWidth - int'(ones));
    end
  end

  assign legal_o = (fine_i == low_run) || (fine_i == high_run);

  // Bit 0 low with ones present means the falling half of the cycle;
  // illegal codes are still decoded with the same rule.
  assign fine_bin_o = (fine_i[0] || (ones == '0))
                    ? ones
                    : FineBinWidth'(2 * FineWidth) - ones;

endmodule

// File: rtl/vco_sample_decoder.sv
// ---------------------------------------------------------------------------
// vco_sample_decoder
//   Snapshots the Gray coarse counter and fine ring state on each trigger,
//   decodes them into a linear phase and outputs the phase increment since
//   the previous accepted sample. Three-stage pipeline, one sample/cycle.
//
//   clk_i          in   1            system clock
//   rst_i          in   1            synchronous active-high reset
//   enable_i       in   1            0 drops triggers and re-arms priming
//   trigger_i      in   1            sample strobe
//   coarse_gray_i  in   CoarseWidth  Gray coarse count (already synchronised)
//   fine_phase_i   in   FineWidth    ring-oscillator snapshot
//   data_o         out  DataWidth    phase increment, held between pulses
//   data_valid_o   out  1            pulse qualifying data_o (trigger + 3)
//   fine_err_o     out  1            sticky illegal-fine-code flag
//   clear_err_i    in   1            clears fine_err_o (new error wins)
//
//   Priming flag:
//   state     | meaning
//   primed=0  | no reference phase yet; next sample at S2 only stores it
//   primed=1  | reference valid; next sample at S2 emits a delta
// ---------------------------------------------------------------------------
module vco_sample_decoder
  import vco_pkg::*;
#(
  parameter int CoarseWidth  = VcoCoarseWidth,
  parameter int FineWidth    = VcoFineWidth,
  parameter int FineBinWidth = VcoFineBinWidth,
  parameter int DataWidth    = VcoDataWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   trigger_i,
  input  logic [CoarseWidth-1:0] coarse_gray_i,
  input  logic [FineWidth-1:0]   fine_phase_i,
  output logic [DataWidth-1:0]   data_o,
  output logic                   data_valid_o,
  output logic                   fine_err_o,
  input  logic                   clear_err_i
);

  localparam int FineStates = 2 * FineWidth;
  localparam logic [DataWidth-1:0] PhaseMod = DataWidth'(FineStates) << CoarseWidth;

  // S0 capture
  logic                   v1_q, v1_d;
  logic [CoarseWidth-1:0] coarse_q, coarse_d;
  logic [FineWidth-1:0]   fine_q, fine_d;

  // S1 decode
  logic [CoarseWidth-1:0]  coarse_bin;
  logic [FineBinWidth-1:0] fine_bin;
  logic                    fine_legal;
  logic                    v2_q, v2_d;
  logic [DataWidth-1:0]    phase_q, phase_d;
  logic                    fine_err_q, fine_err_d;

  // S2 increment
  logic [DataWidth-1:0] delta;
  logic [DataWidth-1:0] prev_phase_q, prev_phase_d;
  logic                 primed_q, primed_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;

  // ---------------- S0: snapshot ----------------
  always_comb begin
    v1_d     = enable_i & trigger_i;
    coarse_d = coarse_q;
    fine_d   = fine_q;
    if (v1_d) begin
      coarse_d = coarse_gray_i;
      fine_d   = fine_phase_i;
    end
  end

  // ---------------- S1: decode ----------------
  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    coarse_bin = '0;
    for (int i = 0; i < CoarseWidth; i++) begin
      coarse_bin[i] = ^(coarse_q >> i);
    end
  end

  vco_fine_decoder #(
    .FineWidth   (FineWidth),
    .FineBinWidth(FineBinWidth)
  ) u_fine_decoder (
    .fine_i    (fine_q),
    .fine_bin_o(fine_bin),
    .legal_o   (fine_legal)
  );

  always_comb begin
    v2_d    = v1_q;
    phase_d = phase_q;
    if (v1_q) begin
      phase_d = DataWidth'(coarse_bin) * DataWidth'(FineStates) + DataWidth'(fine_bin);
    end
  end

  // A fresh error takes priority over a clear in the same cycle.
  always_comb begin
    fine_err_d = fine_err_q & ~clear_err_i;
    if (v1_q && !fine_legal) begin
      fine_err_d = 1'b1;
    end
  end

  // ---------------- S2: increment ----------------
  // The true increment lies in [0, PhaseMod) which fits in DataWidth, so
  // adding PhaseMod after a wrapped subtraction lands on the right value.
  always_comb begin
    if (phase_q < prev_phase_q) begin
      delta = phase_q - prev_phase_q + PhaseMod;
    end else begin
      delta = phase_q - prev_phase_q;
    end
  end

  always_comb begin
    prev_phase_d = prev_phase_q;
    primed_d     = primed_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    if (v2_q) begin
      prev_phase_d = phase_q;
      primed_d     = 1'b1;
      if (primed_q) begin
        data_d       = delta;
        data_valid_d = 1'b1;
      end
    end
    // Samples already in flight still complete; only the priming is lost.
    if (!enable_i) begin
      primed_d = 1'b0;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q         <= 1'b0;
      coarse_q     <= '0;
      fine_q       <= '0;
      v2_q         <= 1'b0;
      phase_q      <= '0;
      fine_err_q   <= 1'b0;
      prev_phase_q <= '0;
      primed_q     <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      coarse_q     <= coarse_d;
      fine_q       <= fine_d;
      v2_q         <= v2_d;
      phase_q      <= phase_d;
      fine_err_q   <= fine_err_d;
      prev_phase_q <= prev_phase_d;
      primed_q     <= primed_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign fine_err_o   = fine_err_q;

endmodule

// File: doc/vco_sample_decoder.md
Name: vco_sample_decoder

Overview:
- Digital back-end stage directly downstream of the VCO-ADC analog core.
- On each trigger it snapshots the free-running coarse edge counter (Gray-coded) and the 31-phase fine ring-oscillator state.
- It decodes both into one linear phase count, then outputs the phase increment since the previous trigger as the 32-bit conversion result.
- data_valid_o asserts exactly VcoTrigger2drDelayCc = 3 cycles after the trigger.

Parameters:
- CoarseWidth, vco_pkg::VcoCoarseWidth (26), coarse counter width.
- FineWidth, vco_pkg::VcoFineWidth (31), number of ring phases.
- FineBinWidth, vco_pkg::VcoFineBinWidth (6), decoded fine-phase width.
- DataWidth, vco_pkg::VcoDataWidth (32), output sample width.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  block enable; 0 ignores triggers and re-arms priming.
- trigger_i  in  1  sample strobe; single-cycle pulse; may assert every cycle.
- coarse_gray_i  in  CoarseWidth  Gray-coded coarse count, already synchronised into clk_i.
- fine_phase_i  in  FineWidth  ring-oscillator phase snapshot (pseudo-thermometer).
- data_o  out  DataWidth  phase increment since the previous accepted sample.
- data_valid_o  out  1  single-cycle pulse qualifying data_o.
- fine_err_o  out  1  sticky flag: an illegal fine code was seen.
- clear_err_i  in  1  clears fine_err_o.

Behaviour:
- Reset: data_o=0, data_valid_o=0, fine_err_o=0, all pipeline valids=0, primed=0, prev_phase=0.
- Stage S0 (trigger cycle T): if enable_i && trigger_i, register coarse_gray_i and fine_phase_i, and set v1.
- Stage S1 (T+1): decode the registered samples.
  - Gray-to-binary on coarse: b[MSB]=g[MSB]; b[i]=b[i+1]^g[i].
  - ones = popcount(fine).
  - fine_bin = (fine[0] || ones==0) ? ones : 62-ones. Range is 0..61.
  - Legal code: fine is a contiguous run of 1s starting at bit 0, or a contiguous run of 0s starting at bit 0 followed by 1s to bit 30.
  - Any other code sets fine_err_o, and decoding proceeds with the formula above.
  - phase = coarse_bin*62 + fine_bin. This is 32 bits; the maximum is 2^26*62-1, which fits.
- Stage S2 (T+2): compute the increment.
  - delta = phase - prev_phase.
  - If phase < prev_phase (coarse wrap), delta += 62*2^26. The arithmetic is modulo PHASE_MOD, not 2^32.
  - Update prev_phase = phase.
  - If primed, register data_o=delta and data_valid_o=1 at T+3. Otherwise set primed=1 and emit nothing.
- Latency: trigger at cycle T gives data_valid_o high during cycle T+3. Fully pipelined, throughput 1 sample/cycle.
- data_o holds its value between valid pulses.
- enable_i deasserted:
  - New triggers are dropped.
  - Samples already in flight complete normally.
  - primed clears, so the first sample after re-enable only primes.
- Reset mid-pipeline clears all in-flight samples; no valid pulse is emitted for them.
- clear_err_i and a new error in the same cycle: the error wins (flag stays 1).
- Equal consecutive phases give delta=0, and valid is still emitted.

Decomposition:
- Add to vco_pkg:
  - VcoFineStates = 2*VcoFineWidth (62).
  - VcoPhaseMod = VcoFineStates << VcoCoarseWidth.
  - typedef vco_phase_t (logic [VcoDataWidth-1:0]).
- One sub-module: vco_fine_decoder. Purely combinational; thermometer-to-fine_bin conversion plus legality check.
- This block instantiates vco_fine_decoder in S1.

Test Plan:
- Reset, then trigger with coarse=bin 10, fine=0x0000_0007 (fine_bin 3) -> no valid output (priming only).
- Next trigger with coarse=bin 11, fine=0x7FFF_FFF8 (ones=28, fine[0]=0, fine_bin 34) -> valid exactly 3 cycles later, data_o = (11*62+34)-(10*62+3) = 93.
- Prev phase = 2^26*62-1; new sample coarse=0, fine=1 (phase 1) -> data_o=2 (wrap correction applied).
- Triggers on 4 consecutive cycles with phases 0, 5, 9, 20 -> 3 back-to-back valids with data_o = 5, 4, 11.
- fine=0x0000_0005 (bubble) -> fine_err_o=1 and stays 1 until clear_err_i; clear_err_i alone -> fine_err_o=0.
- Assert rst_i one cycle after a trigger -> no data_valid_o pulse; the next trigger only primes.
